// File: rtl/vga_pixfetch.sv
// Pixel prefetch for the VGA top: pulls 16-bit words from frame memory over a
// single-outstanding req/ack port into a byte FIFO and hands out one pixel per gated cycle.
module vga_pixfetch #(
  parameter int         FIFO_DEPTH = 32,
  parameter logic [7:0] BORDER     = 8'h00
) (
  input  logic                          i_vgaclk,
  input  logic                          i_reset,
  input  logic                          i_frameStart,
  input  logic [23:0]                   i_base,
  input  logic                          i_pixGate,
  output logic [7:0]                    o_pixData,
  output logic                          o_mem_req,
  output logic [22:0]                   o_mem_addr,
  input  logic                          i_mem_ack,
  input  logic [15:0]                   i_mem_dat,
  output logic                          o_underrun,
  input  logic                          i_clrUnderrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] SPACE_LIM = LW'(FIFO_DEPTH - 2);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_TWO   = AW'(2);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_TWO   = LW'(2);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetchState_t;

  fetchState_t   r_state;
  fetchState_t   w_nextState;
  logic          w_startReq;
  logic [22:0]   r_wordPtr;
  logic [22:0]   r_memAddr;
  logic          r_discard;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;
  logic          r_underrun;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_setUnderrun;
  logic          w_unused;

  assign w_unused = i_base[0];

  always_ff @(posedge i_vgaclk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A new request only starts when two bytes of room exist and no restart is in progress.
  always_comb begin
    w_nextState = r_state;
    w_startReq  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_frameStart && (r_level <= SPACE_LIM)) begin
          w_nextState = S_REQ;
          w_startReq  = 1'b1;
        end
      end
      S_REQ: begin
        if (i_mem_ack) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_empty       = (r_level == '0);
  assign w_push        = (r_state == S_REQ) && i_mem_ack && !i_frameStart && !r_discard;
  assign w_pop         = i_pixGate && !w_empty && !i_frameStart;
  assign w_setUnderrun = i_pixGate && w_empty && !i_frameStart;

  // A request caught by a restart belongs to the old frame; its data must never land.
  always_ff @(posedge i_vgaclk) begin
    if (i_reset) begin
      r_wordPtr <= '0;
      r_memAddr <= '0;
      r_discard <= 1'b0;
    end else begin
      if (i_frameStart) begin
        r_wordPtr <= i_base[23:1];
      end else if (w_push) begin
        r_wordPtr <= r_wordPtr + 23'd1;
      end
      if (w_startReq) begin
        r_memAddr <= r_wordPtr;
      end
      if ((r_state == S_REQ) && i_mem_ack) begin
        r_discard <= 1'b0;
      end else if ((r_state == S_REQ) && i_frameStart) begin
        r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_vgaclk) begin
    if (w_push) begin
      r_fifo[r_wrPtr]           <= i_mem_dat[7:0];
      r_fifo[r_wrPtr + PTR_ONE] <= i_mem_dat[15:8];
    end
  end

  always_ff @(posedge i_vgaclk) begin
    if (i_reset || i_frameStart) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_TWO;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      r_level <= r_level + (w_push ? LVL_TWO : '0) - (w_pop ? LVL_ONE : '0);
    end
  end

  // Set has priority over clear so a fresh underrun is never lost.
  always_ff @(posedge i_vgaclk) begin
    if (i_reset) begin
      r_underrun <= 1'b0;
    end else if (w_setUnderrun) begin
      r_underrun <= 1'b1;
    end else if (i_clrUnderrun) begin
      r_underrun <= 1'b0;
    end
  end

  assign o_pixData  = (i_pixGate && !w_empty) ? r_fifo[r_rdPtr] : BORDER;
  assign o_mem_req  = (r_state == S_REQ);
  assign o_mem_addr = r_memAddr;
  assign o_underrun = r_underrun;
  assign o_level    = r_level;

endmodule

// File: doc/vga_pixfetch.md
# vga_pixfetch

Pixel prefetch stage directly upstream of the VGA top. It reads 16-bit words of 8-bit RGB332 pixels from frame memory through a single-outstanding request/acknowledge read port, buffers them in a byte FIFO, and supplies one pixel per `i_vgaclk` cycle while the top's pixel gate is high. Each frame it restarts from a programmable base address on the frame-start level, normally vSync.

## Interface
- FIFO_DEPTH, 32, FIFO capacity in bytes; power of two, ≥ 4
- BORDER, 8'h00, pixel value driven when gate is low or FIFO is empty
---
- i_vgaclk  in  1  pixel clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_frameStart  in  1  level; high = flush and reload (tie to timing vSync)
- i_base  in  24  frame base byte address; bit 0 ignored
- i_pixGate  in  1  consumer takes one pixel this cycle
- o_pixData  out  8  pixel to consumer, RGB332
- o_mem_req  out  1  read request, registered
- o_mem_addr  out  23  word address = byte address >> 1, registered
- i_mem_ack  in  1  read complete; i_mem_dat valid this cycle
- i_mem_dat  in  16  read data; [7:0] is the earlier pixel
- o_underrun  out  1  sticky: gate seen with empty FIFO
- i_clrUnderrun  in  1  clears o_underrun
- o_level  out  clog2(FIFO_DEPTH)+1  FIFO byte count

## Operation
- Fetch FSM has two states, IDLE and REQ.
  - IDLE → REQ when i_frameStart=0 and o_level + 2 ≤ FIFO_DEPTH. Sets o_mem_req=1. o_mem_addr holds the current word pointer.
  - REQ: o_mem_req and o_mem_addr are held stable until an edge with i_mem_ack=1. On that edge the FSM goes to IDLE, o_mem_req goes to 0, and the pointer increments modulo 2^23.
  - o_mem_req is low for at least one cycle between requests.
- Push on ack: i_mem_dat[7:0] is written first, then [15:8]. Level increases by 2.
  - Overflow cannot occur because of the space check and the single outstanding request.
- Pop: i_pixGate=1 and level>0 removes the head byte.
  - Simultaneous push and pop gives a net level change of +1.
- o_pixData is combinational: head byte when i_pixGate=1 and level>0, else BORDER.
- Underrun: i_pixGate=1 with level=0 sets o_underrun. o_pixData=BORDER. Nothing is popped. The pointer does not skip, so the frame shifts until the next restart.
- i_clrUnderrun clears o_underrun. If a set condition occurs in the same cycle, set wins.
- Frame restart, every cycle i_frameStart=1:
  - FIFO is flushed (level=0, read and write pointers equal).
  - Pointer is loaded with i_base[23:1].
  - No new request is issued.
  - A request already in REQ stays asserted until ack. Its data is discarded, and its ack does not advance the pointer.
  - Pops and underrun detection are disabled.
- Fetching resumes in the first cycle after i_frameStart falls.

## Timing
- Reset values: o_mem_req=0, o_mem_addr=0, o_underrun=0, o_level=0. FSM is in IDLE. o_pixData=BORDER.
- Reset mid-request drops o_mem_req the next cycle. A later stale ack is ignored because the FSM is in IDLE.
- Latency:
  - IDLE → o_mem_req high: 1 cycle after the condition is true.
  - Ack edge → bytes visible on o_level and head: next cycle.
  - Empty FIFO: the ack cycle's low byte is available to the consumer 1 cycle after the ack edge.
- Pop effects (o_level, head) are visible the cycle after the gate edge.
- Sustained throughput is 1 word per 2 cycles when memory acks in the request cycle. This matches the 1 byte/cycle consumption.

## Test plan
- Reset, then i_base=24'h000100 and i_frameStart 1→0 with ack in the first REQ cycle:
  - First request has o_mem_addr=23'h000080.
  - Requests continue until o_level reaches FIFO_DEPTH. For the default of 32 that is 16 requests, with the last word address 23'h00008F.
- Memory words 16'hBBAA, 16'hDDCC, then i_pixGate held high: o_pixData sequence AA, BB, CC, DD and o_underrun stays 0.
- Gate high with level=0: o_pixData=8'h00, o_underrun=1 the next cycle. Clear and set in the same cycle leaves o_underrun=1.
- i_frameStart rises while REQ is outstanding with ack delayed 3 cycles:
  - o_mem_req stays high until the ack.
  - Data is discarded and o_level=0.
  - The next request after the fall uses i_base[23:1].
- Pointer at 23'h7FFFFF: after ack the next o_mem_addr is 23'h000000.
- Simultaneous ack and pop at level 5: level becomes 6. Assert the level never exceeds FIFO_DEPTH over a 10k-cycle random ack/gate run.
